neuron_mac_ctrl: RTL and testbench
==================================

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

Interface
REQ-001 Parameter N, default 16, signed operand and result width.
REQ-002 Parameter FRAC, default 8, fractional bits of operands, bias and result.
REQ-003 Parameter ADDR_W, default 6, operand memory address width; maximum vector length is 2^ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a dot-product job; sampled only in IDLE.
REQ-007 len  input  ADDR_W+1  vector length, 0..2^ADDR_W; captured on start accept.
REQ-008 bias  input  N  signed bias, same Q format as result; captured on start accept.
REQ-009 relu_en  input  1  apply ReLU to the result; captured on start accept.
REQ-010 rd_en  output  1  operand read strobe to weight and input memories.
REQ-011 rd_addr  output  ADDR_W  operand read address.
REQ-012 w_data  input  N  signed weight; valid exactly one cycle after rd_en.
REQ-013 x_data  input  N  signed input; valid exactly one cycle after rd_en.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_data  output  N  signed result.
REQ-018 out_sat  output  1  result was clipped by saturation; qualified by out_valid.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN, POST and OUT.
REQ-020 Start is accepted at a clock edge where state=IDLE and start=1; it clears the accumulator, latches len/bias/relu_en, and moves to RUN if len>0, else to DRAIN.
REQ-021 start is ignored in every state other than IDLE.
REQ-022 In RUN, rd_en=1 and rd_addr=k in the k-th RUN cycle (k=0..len-1); after cycle len-1, state moves to DRAIN.
REQ-023 A registered copy of rd_en marks data-valid; at each edge where it is 1, acc <= acc + w_data*x_data.
REQ-024 The product is a full signed 2N-bit value; the accumulator is 2N bits and wraps modulo 2^(2N) without saturation.
REQ-025 DRAIN lasts one cycle, absorbs the final product, and moves to POST.
REQ-026 In POST: sum = acc + (sign-extended bias << FRAC) (2N-bit, wrapping); shifted = sum arithmetic-shifted right by FRAC.
REQ-027 POST saturates shifted to [-(2^(N-1)), 2^(N-1)-1] and sets out_sat=1 if clipping occurred.
REQ-028 If relu_en is set and the saturated value is negative, out_data SHALL be 0 and out_sat is unaffected.
REQ-029 The POST-to-OUT edge registers out_data and out_sat and sets out_valid=1; out_valid rises exactly len+2 edges after the accept edge (2 for len=0).
REQ-030 In OUT, out_data, out_sat and out_valid are held stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE.
REQ-031 rd_en SHALL be 0 outside RUN; rd_addr holds its last value when rd_en=0.

Reset
REQ-032 rst=0 asynchronously forces IDLE and clears acc, rd_en, rd_addr, busy, out_valid, out_data and out_sat to 0.
REQ-033 Reset during any state discards the job; no out_valid is produced for it.
REQ-034 The first start is accepted at the first edge after rst returns high.

Verification
REQ-035 N=16, FRAC=8, len=3, w=[256,512,-256], x=[256,256,256], bias=0 -> rd_addr 0,1,2 on consecutive cycles; out_valid 5 edges after accept; out_data=512; out_sat=0.
REQ-036 len=1, w=x=32767, bias=0 -> out_data=32767, out_sat=1; repeat with w=32767, x=-32768 -> out_data=-32768, out_sat=1.
REQ-037 len=1, w=256, x=-512, bias=0: relu_en=0 -> out_data=-512; relu_en=1 -> out_data=0.
REQ-038 len=0, bias=-384 -> rd_en never asserted; out_valid 2 edges after accept; out_data=-384.
REQ-039 Hold out_ready=0 for 4 cycles with start pulsed meanwhile -> out_data stable, busy=1, start ignored; out_ready=1 -> transfer, busy=0 next cycle, next start accepted.
REQ-040 Assert rst=0 in the 2nd RUN cycle of a len=8 job -> all outputs 0 immediately; a new len=1 job then produces the correct result with no residue.

Source files
------------

// File: rtl/neuron_mac_ctrl.sv
// Sequenced signed dot product with bias, saturation and optional ReLU; result valid len+2 edges after start.
// Result is held in OUT until out_ready; start is only honoured in IDLE.
module neuron_mac_ctrl #(
  parameter int N      = 16,
  parameter int FRAC   = 8,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  input  logic signed [N-1:0] bias,
  input  logic                relu_en,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic signed [N-1:0] w_data,
  input  logic signed [N-1:0] x_data,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                out_sat
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, POST, OUT} state_t;

  localparam logic signed [2*N-1:0] MAXV = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MINV = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  state_t                state, state_nxt;
  logic [ADDR_W:0]       len_q;
  logic signed [N-1:0]   bias_q;
  logic                  relu_q;
  logic                  dv;
  logic                  last;
  logic [2*N-1:0]        prod;
  logic signed [2*N-1:0] acc, sum, shifted;
  logic signed [N-1:0]   res;
  logic                  res_sat;

  assign last = ({1'b0, rd_addr} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len != '0) ? RUN : DRAIN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = POST;
      POST:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are widened first so the product is exact; the accumulator wraps mod 2^(2N).
  always_comb begin
    prod    = {{N{w_data[N-1]}}, w_data} * {{N{x_data[N-1]}}, x_data};
    sum     = acc + ({{N{bias_q[N-1]}}, bias_q} << FRAC);
    shifted = sum >>> FRAC;
    res     = shifted[N-1:0];
    res_sat = 1'b0;
    if (shifted > MAXV) begin
      res     = MAXV[N-1:0];
      res_sat = 1'b1;
    end else if (shifted < MINV) begin
      res     = MINV[N-1:0];
      res_sat = 1'b1;
    end
    if (relu_q && res[N-1]) res = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      dv        <= 1'b0;
      acc       <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      dv    <= rd_en;
      if (state == IDLE && start) begin
        acc    <= '0;
        len_q  <= len;
        bias_q <= bias;
        relu_q <= relu_en;
        if (len != '0) rd_addr <= '0;
      end else if (dv) begin
        acc <= acc + prod;
      end
      // Address stops on the last element so it holds len-1 once reads end.
      if (state == RUN && !last) rd_addr <= rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (state == POST) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_sat   <= res_sat;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed jobs with hand-computed results; a queue-based scoreboard is checked by a monitor on each
// result handshake, while the driver checks latency, read sequencing, backpressure and reset.
module tb_neuron_mac_ctrl;
  localparam int N = 16, FRAC = 8, AW = 6;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic [AW:0] len = '0;
  logic signed [N-1:0] bias = '0, w_data = '0, x_data = '0, out_data;
  logic rd_en, busy, out_valid, out_sat;
  logic [AW-1:0] rd_addr;

  int errors = 0, checks = 0;
  logic signed [N-1:0] wmem [64];
  logic signed [N-1:0] xmem [64];

  typedef struct {
    logic signed [N-1:0] data;
    logic                sat;
  } exp_t;
  exp_t sb [$];

  neuron_mac_ctrl #(.N(N), .FRAC(FRAC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .relu_en(relu_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_data(w_data), .x_data(x_data), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Operand memories: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= wmem[rd_addr];
      x_data <= xmem[rd_addr];
    end
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
      end
    end
  end

  task automatic setmem(input int i, input int w, input int x);
    wmem[i] = w[N-1:0];
    xmem[i] = x[N-1:0];
  endtask

  task automatic run_job(input string tag, input int l, input int b, input logic r,
                         input int ed, input logic es, input int hold);
    int n;
    logic bad;
    logic signed [N-1:0] held;
    exp_t e;
    e.data = ed[N-1:0];
    e.sat  = es;
    sb.push_back(e);
    out_ready = (hold == 0);
    len = l[AW:0];
    bias = b[N-1:0];
    relu_en = r;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    bad = 1'b0;
    while (!out_valid && n < 200) begin
      if (rd_en !== (n < l)) bad = 1'b1;
      if (rd_en && rd_addr !== n[AW-1:0]) bad = 1'b1;
      @(posedge clk); #2;
      n++;
    end
    check({tag, " latency"}, n, l + 2);
    check({tag, " rd_seq"}, {31'd0, bad}, 0);
    if (hold > 0) begin
      held = out_data;
      for (int i = 0; i < hold; i++) begin
        start = 1'b1;
        @(posedge clk); #2;
        check({tag, " hold_data"}, out_data, held);
        check({tag, " hold_valid"}, {31'd0, out_valid}, 1);
        check({tag, " hold_busy"}, {31'd0, busy}, 1);
      end
      start = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #2;
    check({tag, " busy_after"}, {31'd0, busy}, 0);
    check({tag, " valid_after"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) setmem(i, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("rst rd_en", {31'd0, rd_en}, 0);
    check("rst rd_addr", {26'd0, rd_addr}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst out_valid", {31'd0, out_valid}, 0);
    check("rst out_data", out_data, 0);
    check("rst out_sat", {31'd0, out_sat}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    setmem(0, 256, 256); setmem(1, 512, 256); setmem(2, -256, 256);
    run_job("dot3", 3, 0, 1'b0, 512, 1'b0, 0);
    setmem(0, 32767, 32767);
    run_job("sat_pos", 1, 0, 1'b0, 32767, 1'b1, 0);
    setmem(0, 32767, -32768);
    run_job("sat_neg", 1, 0, 1'b0, -32768, 1'b1, 0);
    run_job("sat_neg_relu", 1, 0, 1'b1, 0, 1'b1, 0);
    setmem(0, 256, -512);
    run_job("neg_norelu", 1, 0, 1'b0, -512, 1'b0, 0);
    run_job("neg_relu", 1, 0, 1'b1, 0, 1'b0, 0);
    run_job("len0_bias", 0, -384, 1'b0, -384, 1'b0, 0);
    setmem(0, 256, 256);
    run_job("backpressure", 1, 0, 1'b0, 256, 1'b0, 4);
    setmem(0, 512, 512); setmem(1, -256, 512);
    run_job("after_hold", 2, 128, 1'b0, 640, 1'b0, 0);
    for (int i = 0; i < 64; i++) setmem(i, 256, 256);
    run_job("len_max", 64, 0, 1'b0, 16384, 1'b0, 0);

    // Abort a len=8 job in its second RUN cycle
    setmem(0, 512, 512); setmem(1, -256, 512);
    len = 8;
    bias = 0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    check("abort rd_addr_pre", {26'd0, rd_addr}, 1);
    rst = 1'b0;
    #1;
    check("abort rd_en", {31'd0, rd_en}, 0);
    check("abort rd_addr", {26'd0, rd_addr}, 0);
    check("abort busy", {31'd0, busy}, 0);
    check("abort out_valid", {31'd0, out_valid}, 0);
    check("abort out_data", out_data, 0);
    check("abort out_sat", {31'd0, out_sat}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    setmem(0, 256, 768);
    run_job("post_reset", 1, 256, 1'b0, 1024, 1'b0, 0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
